// File: rtl/cvrp_pkg.sv
// Shared types and constants for the CVRP run scheduler.
package cvrp_pkg;

  localparam int unsigned COST_WIDTH   = 24;
  localparam int unsigned RUN_ID_WIDTH = 8;

  // "No result yet" marker for the best-cost register.
  localparam logic [COST_WIDTH-1:0] COST_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_BARRIER,
    ST_IMPROVE,
    ST_DRAIN,
    ST_FIN
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at a rotating
// pointer; the pointer moves past the granted index when adv_i is set.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d, nxt_ptr, idx_p;
  logic          found;
  int unsigned   idx;

  // Priority search from the pointer, wrapping modulo N.
  always_comb begin
    gnt_o   = '0;
    found   = 1'b0;
    nxt_ptr = ptr_q;
    idx     = 0;
    idx_p   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx   = (32'(ptr_q) + i) % N;
      idx_p = PW'(idx);
      if (!found && req_i[idx_p]) begin
        gnt_o[idx_p] = 1'b1;
        found        = 1'b1;
        nxt_ptr      = PW'((idx + 1) % N);
      end
    end
    ptr_d = (adv_i && found) ? nxt_ptr : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/run_scheduler.sv
// Sequences init runs, a phase barrier, then improvement runs across the
// processing-node array; collects results and tracks the lowest cost.
module run_scheduler
  import cvrp_pkg::*;
#(
  parameter int unsigned pNumProcessingNodes = 16,
  parameter int unsigned pNumInitRuns        = 20,
  parameter int unsigned pNumRuns            = 68,
  parameter int unsigned pCostWidth          = COST_WIDTH,
  parameter int unsigned pRunIdWidth         = RUN_ID_WIDTH
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       start_i,
  input  logic [pNumProcessingNodes-1:0]             node_idle_i,
  output logic [pNumProcessingNodes-1:0]             node_start_o,
  output logic [pRunIdWidth-1:0]                     node_run_id_o,
  output logic                                       node_init_o,
  input  logic [pNumProcessingNodes-1:0]             node_done_i,
  input  logic [pNumProcessingNodes*pCostWidth-1:0]  node_cost_i,
  input  logic [pNumProcessingNodes*pRunIdWidth-1:0] node_run_id_i,
  output logic [pNumProcessingNodes-1:0]             node_ack_o,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic [pCostWidth-1:0]                      best_cost_o,
  output logic [pRunIdWidth-1:0]                     best_run_o,
  output logic [pRunIdWidth-1:0]                     runs_issued_o
);

  localparam int unsigned N = pNumProcessingNodes;
  localparam logic [pRunIdWidth-1:0] INIT_RUNS  = pRunIdWidth'(pNumInitRuns);
  localparam logic [pRunIdWidth-1:0] TOTAL_RUNS = pRunIdWidth'(pNumRuns);

  state_e                  state_q, state_d;
  logic [pRunIdWidth-1:0]  issued_q, issued_d;
  logic [pRunIdWidth-1:0]  collected_q, collected_d;
  logic [N-1:0]            pending_q, pending_d;
  logic [N-1:0]            start_q, start_d;
  logic [N-1:0]            ack_q, ack_d;
  logic [pRunIdWidth-1:0]  run_id_q, run_id_d;
  logic                    init_q, init_d;
  logic [pCostWidth-1:0]   best_cost_q, best_cost_d;
  logic [pRunIdWidth-1:0]  best_run_q, best_run_d;

  logic                    disp_en, coll_en;
  logic [N-1:0]            disp_req, disp_gnt, coll_req, coll_gnt;
  logic [pCostWidth-1:0]   coll_cost;
  logic [pRunIdWidth-1:0]  coll_id;

  // Request gating. A node being collected this cycle is withheld from
  // dispatch so collection always wins a same-node collision.
  always_comb begin
    disp_en  = ((state_q == ST_INIT)    && (issued_q < INIT_RUNS)) ||
               ((state_q == ST_IMPROVE) && (issued_q < TOTAL_RUNS));
    coll_en  = (state_q != ST_IDLE);
    coll_req = coll_en ? (node_done_i & pending_q) : '0;
    disp_req = disp_en ? (node_idle_i & ~pending_q & ~coll_gnt) : '0;
  end

  rr_arbiter #(.N(N)) u_disp_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (disp_req),
    .adv_i  (disp_en),
    .gnt_o  (disp_gnt)
  );

  rr_arbiter #(.N(N)) u_coll_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (coll_req),
    .adv_i  (coll_en),
    .gnt_o  (coll_gnt)
  );

  // Select the cost and run ID of the node being collected.
  always_comb begin
    coll_cost = '0;
    coll_id   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (coll_gnt[k]) begin
        coll_cost = node_cost_i[k*pCostWidth +: pCostWidth];
        coll_id   = node_run_id_i[k*pRunIdWidth +: pRunIdWidth];
      end
    end
  end

  // Phase sequencing plus dispatch/collect bookkeeping.
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    collected_d = collected_q;
    pending_d   = pending_q;
    start_d     = '0;
    ack_d       = '0;
    run_id_d    = run_id_q;
    init_d      = 1'b0;
    best_cost_d = best_cost_q;
    best_run_d  = best_run_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_INIT;
          issued_d    = '0;
          collected_d = '0;
          pending_d   = '0;
          best_cost_d = '1;
          best_run_d  = '0;
        end
      end
      ST_INIT:    if (issued_q == INIT_RUNS) state_d = ST_BARRIER;
      ST_BARRIER: if (collected_q == INIT_RUNS)
                    state_d = (INIT_RUNS == TOTAL_RUNS) ? ST_FIN : ST_IMPROVE;
      ST_IMPROVE: if (issued_q == TOTAL_RUNS) state_d = ST_DRAIN;
      ST_DRAIN:   if (collected_q == TOTAL_RUNS) state_d = ST_FIN;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (|disp_gnt) begin
      start_d   = disp_gnt;
      run_id_d  = issued_q;
      init_d    = (state_q == ST_INIT);
      pending_d = pending_d | disp_gnt;
      if (issued_q != TOTAL_RUNS) issued_d = issued_q + 1'b1;
    end

    if (|coll_gnt) begin
      ack_d     = coll_gnt;
      pending_d = pending_d & ~coll_gnt;
      if (collected_q != TOTAL_RUNS) collected_d = collected_q + 1'b1;
      if (coll_cost < best_cost_q) begin
        best_cost_d = coll_cost;
        best_run_d  = coll_id;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      issued_q    <= '0;
      collected_q <= '0;
      pending_q   <= '0;
      start_q     <= '0;
      ack_q       <= '0;
      run_id_q    <= '0;
      init_q      <= 1'b0;
      best_cost_q <= '1;
      best_run_q  <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      collected_q <= collected_d;
      pending_q   <= pending_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      run_id_q    <= run_id_d;
      init_q      <= init_d;
      best_cost_q <= best_cost_d;
      best_run_q  <= best_run_d;
    end
  end

  assign node_start_o  = start_q;
  assign node_ack_o    = ack_q;
  assign node_run_id_o = run_id_q;
  assign node_init_o   = init_q;
  assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done_o        = (state_q == ST_FIN);
  assign best_cost_o   = best_cost_q;
  assign best_run_o    = best_run_q;
  assign runs_issued_o = issued_q;

endmodule

// File: tb/tb_run_scheduler.sv
// Bench for run_scheduler: a table-driven sequence on an N=4/init0/runs8
// instance and a scoreboarded node model on an N=4/init2/runs4 instance.
module tb_run_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 24;
  localparam int unsigned RW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // ---------------- DUT A: init 2, runs 4, driven by node model ----------
  logic              rst_a_n = 1'b0;
  logic              start_a = 1'b0;
  logic [N-1:0]      idle_a  = '1;
  logic [N-1:0]      done_a  = '0;
  logic [N*CW-1:0]   cost_a  = '0;
  logic [N*RW-1:0]   rid_a   = '0;
  logic [N-1:0]      st_a, ack_a;
  logic [RW-1:0]     id_a, brun_a, iss_a;
  logic              init_a, busy_a, fin_a;
  logic [CW-1:0]     best_a;

  run_scheduler #(.pNumProcessingNodes(N), .pNumInitRuns(2), .pNumRuns(4),
                  .pCostWidth(CW), .pRunIdWidth(RW)) dut_a (
    .clk_i(clk), .rst_ni(rst_a_n), .start_i(start_a), .node_idle_i(idle_a),
    .node_start_o(st_a), .node_run_id_o(id_a), .node_init_o(init_a),
    .node_done_i(done_a), .node_cost_i(cost_a), .node_run_id_i(rid_a),
    .node_ack_o(ack_a), .busy_o(busy_a), .done_o(fin_a),
    .best_cost_o(best_a), .best_run_o(brun_a), .runs_issued_o(iss_a));

  // ---------------- DUT B: init 0, runs 8, driven from a table ------------
  logic              rst_b_n = 1'b0;
  logic              start_b = 1'b0;
  logic [N-1:0]      idle_b  = '0;
  logic [N-1:0]      done_b  = '0;
  logic [N*CW-1:0]   cost_b  = '0;
  logic [N*RW-1:0]   rid_b   = {8'd3, 8'd2, 8'd1, 8'd0};
  logic [N-1:0]      st_b, ack_b;
  logic [RW-1:0]     id_b, brun_b, iss_b;
  logic              init_b, busy_b, fin_b;
  logic [CW-1:0]     best_b;

  run_scheduler #(.pNumProcessingNodes(N), .pNumInitRuns(0), .pNumRuns(8),
                  .pCostWidth(CW), .pRunIdWidth(RW)) dut_b (
    .clk_i(clk), .rst_ni(rst_b_n), .start_i(start_b), .node_idle_i(idle_b),
    .node_start_o(st_b), .node_run_id_o(id_b), .node_init_o(init_b),
    .node_done_i(done_b), .node_cost_i(cost_b), .node_run_id_i(rid_b),
    .node_ack_o(ack_b), .busy_o(busy_b), .done_o(fin_b),
    .best_cost_o(best_b), .best_run_o(brun_b), .runs_issued_o(iss_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- Node model and scoreboard for DUT A --------------------
  typedef struct { int unsigned node; logic [RW-1:0] id; logic init; } disp_t;
  disp_t          exp_disp[$];
  int unsigned    exp_ack[$];
  int unsigned    tmr[N];
  logic           nbusy[N];
  logic [RW-1:0]  nid[N];
  logic [CW-1:0]  ctab[4] = '{24'd50, 24'd30, 24'd30, 24'd40};
  logic [CW-1:0]  m_best = '1;
  logic [RW-1:0]  m_run = '0;
  int unsigned    acks_seen = 0;
  int unsigned    fin_cnt = 0;

  always @(negedge clk) begin
    disp_t e;
    int unsigned q;
    if (start_a) begin
      exp_disp.push_back('{0, 8'd0, 1'b1});
      exp_disp.push_back('{1, 8'd1, 1'b1});
      exp_disp.push_back('{2, 8'd2, 1'b0});
      exp_disp.push_back('{3, 8'd3, 1'b0});
    end
    if (fin_a) fin_cnt++;
    if (st_a != '0) chk("a_start_onehot", 32'($countones(st_a)), 1);
    for (int k = 0; k < N; k++) begin
      if (st_a[k]) begin
        if (exp_disp.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_disp_unexpected: node %0d id %0d, expected none", k, id_a);
        end else begin
          e = exp_disp.pop_front();
          chk("a_disp_node", k, e.node);
          chk("a_disp_id", 32'(id_a), 32'(e.id));
          chk("a_disp_init", 32'(init_a), 32'(e.init));
          if (!e.init) chk("a_barrier_acks", acks_seen, 2);
        end
        nbusy[k] = 1'b1; tmr[k] = 5; nid[k] = id_a; idle_a[k] = 1'b0;
      end
      if (ack_a[k]) begin
        if (exp_ack.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_ack_unexpected: node %0d, expected none", k);
        end else begin
          q = exp_ack.pop_front();
          chk("a_ack_node", k, q);
        end
        acks_seen++;
        if (ctab[nid[k][1:0]] < m_best) begin
          m_best = ctab[nid[k][1:0]];
          m_run  = nid[k];
        end
        chk("a_best_cost", 32'(best_a), 32'(m_best));
        chk("a_best_run", 32'(brun_a), 32'(m_run));
        done_a[k] = 1'b0; nbusy[k] = 1'b0; idle_a[k] = 1'b1;
      end else if (nbusy[k] && !done_a[k] && tmr[k] > 0) begin
        tmr[k]--;
        if (tmr[k] == 0) begin
          done_a[k] = 1'b1;
          cost_a[k*CW +: CW] = ctab[nid[k][1:0]];
          rid_a[k*RW +: RW]  = nid[k];
          exp_ack.push_back(k);
        end
      end
    end
  end

  // ---------------- Table for DUT B -----------------------------------------
  typedef struct {
    logic          start;
    logic [N-1:0]  idle;
    logic [N-1:0]  done;
    logic [CW-1:0] cost;
    logic [N-1:0]  e_start;
    logic [RW-1:0] e_id;
    logic [N-1:0]  e_ack;
    logic          e_busy;
    logic [RW-1:0] e_iss;
    logic [CW-1:0] e_best;
    logic [RW-1:0] e_brun;
  } vec_t;

  vec_t vt[16];

  initial begin
    logic seen;
    // start, idle, done, cost | start, id, ack, busy, issued, best, best_run
    vt[0]  = '{1'b1, 4'h0, 4'h0, 24'd0,   4'h0, 8'd0, 4'h0, 1'b1, 8'd0, 24'hFFFFFF, 8'd0};
    vt[1]  = '{1'b0, 4'hF, 4'h0, 24'd0,   4'h0, 8'd0, 4'h0, 1'b1, 8'd0, 24'hFFFFFF, 8'd0};
    vt[2]  = '{1'b0, 4'hF, 4'h0, 24'd0,   4'h0, 8'd0, 4'h0, 1'b1, 8'd0, 24'hFFFFFF, 8'd0};
    vt[3]  = '{1'b0, 4'hF, 4'h0, 24'd0,   4'h1, 8'd0, 4'h0, 1'b1, 8'd1, 24'hFFFFFF, 8'd0};
    vt[4]  = '{1'b0, 4'hF, 4'h0, 24'd0,   4'h2, 8'd1, 4'h0, 1'b1, 8'd2, 24'hFFFFFF, 8'd0};
    vt[5]  = '{1'b0, 4'hF, 4'h0, 24'd0,   4'h4, 8'd2, 4'h0, 1'b1, 8'd3, 24'hFFFFFF, 8'd0};
    vt[6]  = '{1'b0, 4'hF, 4'h0, 24'd0,   4'h8, 8'd3, 4'h0, 1'b1, 8'd4, 24'hFFFFFF, 8'd0};
    vt[7]  = '{1'b0, 4'hF, 4'h0, 24'd0,   4'h0, 8'd0, 4'h0, 1'b1, 8'd4, 24'hFFFFFF, 8'd0};
    vt[8]  = '{1'b0, 4'h0, 4'hA, 24'd100, 4'h0, 8'd0, 4'h2, 1'b1, 8'd4, 24'd100, 8'd1};
    vt[9]  = '{1'b0, 4'h0, 4'h8, 24'd100, 4'h0, 8'd0, 4'h8, 1'b1, 8'd4, 24'd100, 8'd1};
    vt[10] = '{1'b0, 4'h0, 4'h2, 24'd5,   4'h0, 8'd0, 4'h0, 1'b1, 8'd4, 24'd100, 8'd1};
    vt[11] = '{1'b0, 4'h1, 4'h1, 24'd200, 4'h0, 8'd0, 4'h1, 1'b1, 8'd4, 24'd100, 8'd1};
    vt[12] = '{1'b0, 4'hB, 4'h0, 24'd0,   4'h1, 8'd4, 4'h0, 1'b1, 8'd5, 24'd100, 8'd1};
    vt[13] = '{1'b0, 4'hB, 4'h0, 24'd0,   4'h2, 8'd5, 4'h0, 1'b1, 8'd6, 24'd100, 8'd1};
    vt[14] = '{1'b0, 4'hB, 4'h0, 24'd0,   4'h8, 8'd6, 4'h0, 1'b1, 8'd7, 24'd100, 8'd1};
    vt[15] = '{1'b0, 4'hB, 4'h4, 24'd7,   4'h0, 8'd0, 4'h4, 1'b1, 8'd7, 24'd7,   8'd2};

    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge clk);
    chk("a_rst_busy", 32'(busy_a), 0);
    chk("a_rst_best", 32'(best_a), 32'hFFFFFF);
    chk("b_rst_start", 32'(st_b), 0);
    chk("b_rst_ack", 32'(ack_b), 0);
    chk("b_rst_issued", 32'(iss_b), 0);

    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      start_b = vt[r].start;
      idle_b  = vt[r].idle;
      done_b  = vt[r].done;
      cost_b  = {N{vt[r].cost}};
      @(posedge clk);
      #1;
      chk($sformatf("b_row%0d_start", r), 32'(st_b), 32'(vt[r].e_start));
      if (vt[r].e_start != '0) begin
        chk($sformatf("b_row%0d_id", r), 32'(id_b), 32'(vt[r].e_id));
        chk($sformatf("b_row%0d_init", r), 32'(init_b), 0);
      end
      chk($sformatf("b_row%0d_ack", r), 32'(ack_b), 32'(vt[r].e_ack));
      chk($sformatf("b_row%0d_busy", r), 32'(busy_b), 32'(vt[r].e_busy));
      chk($sformatf("b_row%0d_issued", r), 32'(iss_b), 32'(vt[r].e_iss));
      chk($sformatf("b_row%0d_best", r), 32'(best_b), 32'(vt[r].e_best));
      chk($sformatf("b_row%0d_brun", r), 32'(brun_b), 32'(vt[r].e_brun));
    end

    // Asynchronous reset in the middle of IMPROVE, away from any clock edge.
    @(negedge clk);
    idle_b = '0;
    done_b = '0;
    #2 rst_b_n = 1'b0;
    #1;
    chk("b_arst_busy", 32'(busy_b), 0);
    chk("b_arst_done", 32'(fin_b), 0);
    chk("b_arst_best", 32'(best_b), 32'hFFFFFF);
    chk("b_arst_brun", 32'(brun_b), 0);
    chk("b_arst_issued", 32'(iss_b), 0);
    chk("b_arst_start", 32'(st_b), 0);
    chk("b_arst_ack", 32'(ack_b), 0);
    @(negedge clk);
    rst_b_n = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    idle_b  = '1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (st_b != '0) seen = 1'b1;
    end
    chk("b_restart_seen", 32'(seen), 1);
    chk("b_restart_node", 32'(st_b), 1);
    chk("b_restart_id", 32'(id_b), 0);
    chk("b_restart_busy", 32'(busy_b), 1);

    // Full session on DUT A through the node model.
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 300 && fin_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("a_done_pulses", fin_cnt, 1);
    chk("a_final_busy", 32'(busy_a), 0);
    chk("a_final_best", 32'(best_a), 30);
    chk("a_final_brun", 32'(brun_a), 1);
    chk("a_final_issued", 32'(iss_a), 4);
    chk("a_acks_total", acks_seen, 4);
    chk("a_disp_left", exp_disp.size(), 0);
    chk("a_ack_left", exp_ack.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
